key_schedule_ctrl: RTL
======================

Name: key_schedule_ctrl

Overview:
Sequences the single-round key generator (rc, keyIn -> keyout) iteratively to expand one AES-128 cipher key into all 11 round keys (rk0..rk10), one round per clock. Stores the round keys in an internal register file and serves them to the round datapath through an indexed read port. Sits between the key-load interface and the encryption round controller.

Parameters:
NUM_ROUNDS, 10, number of generated round keys; fixed at 10 for AES-128; rc sequence 0..NUM_ROUNDS-1
KEY_W, 128, key and round-key width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request expansion of key_in; sampled only when not busy
key_in  input  128  cipher key; sampled on the accepted start edge
busy  output  1  high while expansion is in progress
done  output  1  one-cycle pulse when rk10 has been written
keys_valid  output  1  high when all 11 round keys belong to the last accepted key
kg_rc  output  4  round constant index to the key generator
kg_key_in  output  128  previous round key to the key generator
kg_key_out  input  128  next round key from the key generator (combinational)
rk_rd_idx  input  4  round-key index 0..10
rk_rd_data  output  128  registered round-key read data

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, round_cnt=0, cur_key=0, all 11 rk entries=0, busy=0, done=0, keys_valid=0, rk_rd_data=0.
- kg_key_in = cur_key (registered). kg_rc = round_cnt in EXPAND, 4'hF otherwise (the generator treats this as rcon=0).
- State IDLE/DONE_ST + start=1 at edge 0: rk[0]<=key_in, cur_key<=key_in, round_cnt<=0, keys_valid<=0, state<=EXPAND.
- EXPAND, each edge: rk[round_cnt+1]<=kg_key_out, cur_key<=kg_key_out, round_cnt<=round_cnt+1.
  - If round_cnt==NUM_ROUNDS-1: state<=DONE_ST, done<=1 for one cycle, keys_valid<=1, round_cnt<=0.
- Latency: start accepted at edge 0; rk1..rk10 written at edges 1..10; done high for the cycle after edge 10.
- busy = (state==EXPAND); combinational from state.
- start while busy: ignored, no effect on the sequence and no queuing.
- start in the same cycle that done is high (state DONE_ST): accepted; new expansion begins and keys_valid drops at that edge.
- DONE_ST with no start: holds, keys_valid stays 1, done=0 after its single cycle.
- Read port: rk_rd_data<=rk[rk_rd_idx] every edge (1-cycle latency, independent of state). rk_rd_idx>10 -> 0. Reads during EXPAND return current array contents, which may be stale; consumers gate on keys_valid.
- Write and read of the same entry on the same edge: read returns the old value.
- Reset mid-expansion: abort immediately; all state and array cleared per reset values; no done pulse.
- round_cnt is 4 bits and never exceeds NUM_ROUNDS-1 in EXPAND.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy for exactly 10 cycles; done single pulse; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6; rk0 equals key_in.
- key_in=000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5; kg_rc sequence 0..9 observed on cycles 1..10, 4'hF otherwise.
- Assert start with a different key at cycle 4 of expansion -> ignored; final keys still match the first key; only one done pulse.
- Start with a second key in the cycle done is high -> keys_valid falls, new 10-cycle expansion, keys of the second key read back correctly.
- Deassert rst_n at cycle 6 of expansion -> outputs and reads of all indices return 0 immediately/next cycle; no done; restart after reset completes normally.
- Read idx 11..15 -> rk_rd_data=0; read idx 5 while keys_valid=1 -> data matches rk5 one cycle later.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion sequencer: drives an external single-round key
// generator once per clock and keeps rk0..rk10 in a register file with a registered read port.
module key_schedule_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic [3:0]       kg_rc,
    output logic [KEY_W-1:0] kg_key_in,
    input  logic [KEY_W-1:0] kg_key_out,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DONE_ST = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       round_cnt_q, round_cnt_d;
    logic [KEY_W-1:0] cur_key_q, cur_key_d;
    logic [KEY_W-1:0] rk_q [NUM_ROUNDS+1];
    logic [KEY_W-1:0] rk_d [NUM_ROUNDS+1];
    logic             done_q, done_d;
    logic             keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0] rd_data_q, rd_data_d;
    logic             last_round;

    assign last_round = (round_cnt_q == 4'(NUM_ROUNDS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE_ST: if (start) state_d = EXPAND;
            EXPAND:        if (last_round) state_d = DONE_ST;
            default:       state_d = IDLE;
        endcase
    end

    // FSM outputs; rc 4'hF tells the generator to use rcon = 0
    always_comb begin
        busy  = (state_q == EXPAND);
        kg_rc = (state_q == EXPAND) ? round_cnt_q : 4'hF;
    end

    always_comb begin
        round_cnt_d  = round_cnt_q;
        cur_key_d    = cur_key_q;
        rk_d         = rk_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        case (state_q)
            IDLE, DONE_ST: begin
                if (start) begin
                    rk_d[0]      = key_in;
                    cur_key_d    = key_in;
                    round_cnt_d  = '0;
                    keys_valid_d = 1'b0;
                end
            end
            EXPAND: begin
                for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
                    if (4'(i) == round_cnt_q + 4'd1) rk_d[i] = kg_key_out;
                end
                cur_key_d = kg_key_out;
                if (last_round) begin
                    round_cnt_d  = '0;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                end else begin
                    round_cnt_d = round_cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Read mux samples the array before this edge's write, so a same-entry read returns the old value
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
            if (rk_rd_idx == 4'(i)) rd_data_d = rk_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt_q  <= '0;
            cur_key_q    <= '0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_data_q    <= '0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
        end else begin
            round_cnt_q  <= round_cnt_d;
            cur_key_q    <= cur_key_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            rd_data_q    <= rd_data_d;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign kg_key_in  = cur_key_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rk_rd_data = rd_data_q;

endmodule
